// File: rtl/exe_stage.sv
// exe_stage: RISC-V execute stage holding the ID/EX register, forwarding muxes, ALU,
// branch/JAL resolution with fetch redirect, and the EXE-to-MEM bus.
module exe_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flushE,
    input  logic            bubbleE,
    input  logic [155:0]    id_to_exe_bus,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic [104:0]    exe_to_mem_bus,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [4:0]      rs_exe,
    output logic [4:0]      rt_exe,
    output logic [4:0]      rd_exe,
    output logic            reg_w_en_exe,
    output logic            dm_r_en_exe
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [XLEN-1:0] rs_value;
        logic [XLEN-1:0] rt_value;
        logic [4:0]      rd;
        logic            alu_src1_is_pc;
        logic            alu_src2_is_4;
        logic            alu_src2_is_imm;
        logic [1:0]      alu_op;
        logic [XLEN-1:0] imm;
        logic            br_beq;
        logic            br_blt;
        logic            br_bltu;
        logic            br_jal;
        logic            mem_to_reg;
        logic            reg_w_en;
        logic            dm_w_en;
        logic            dm_r_en;
    } id_ex_t;

    id_ex_t          ex_q, ex_d;
    logic [XLEN-1:0] fa, fb, src1, src2, alu_result;
    logic            taken;

    // flush outranks bubble; an all-zero register behaves as a NOP
    always_comb ex_d = flushE ? id_ex_t'('0) : bubbleE ? ex_q : id_ex_t'(id_to_exe_bus);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    always_comb begin
        fa = fwd_a_sel == 2'b01 ? mem_fwd_data : fwd_a_sel == 2'b10 ? wb_fwd_data : ex_q.rs_value;
        fb = fwd_b_sel == 2'b01 ? mem_fwd_data : fwd_b_sel == 2'b10 ? wb_fwd_data : ex_q.rt_value;
        src1 = ex_q.alu_src1_is_pc ? ex_q.pc : fa;
        src2 = ex_q.alu_src2_is_4 ? XLEN'(4) : ex_q.alu_src2_is_imm ? ex_q.imm : fb;
        alu_result = ex_q.alu_op == 2'b00 ? src1 + src2 :
                     ex_q.alu_op == 2'b01 ? src1 - src2 :
                     ex_q.alu_op == 2'b10 ? src1 & src2 : src1 | src2;
        taken = ex_q.br_jal | (ex_q.br_beq & (fa == fb)) |
                (ex_q.br_blt & ($signed(fa) < $signed(fb))) | (ex_q.br_bltu & (fa < fb));
    end

    assign redirect_valid = taken;
    assign redirect_pc    = ex_q.pc + ex_q.imm;
    assign exe_to_mem_bus = {ex_q.pc, alu_result, fb, ex_q.rd,
                             ex_q.mem_to_reg, ex_q.reg_w_en, ex_q.dm_w_en, ex_q.dm_r_en};
    assign rs_exe         = ex_q.rs;
    assign rt_exe         = ex_q.rt;
    assign rd_exe         = ex_q.rd;
    assign reg_w_en_exe   = ex_q.reg_w_en;
    assign dm_r_en_exe    = ex_q.dm_r_en;
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Sits directly downstream of the decode stage and consumes its 156-bit decode-to-execute bus.
- Owns the ID/EX pipeline register, including bubble (hold) and flush (NOP insert) control.
- Applies operand forwarding, computes the ALU result, resolves branches and JAL, and emits a redirect to fetch.
- Produces the execute-to-memory bus plus hazard-detection taps.

Parameters:
- XLEN, 32, datapath width (fixed at 32; width field calculations below assume it).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- flushE  in  1  load a NOP into the ID/EX register at the next edge.
- bubbleE  in  1  hold the ID/EX register at the next edge.
- id_to_exe_bus  in  156  decode bundle. MSB→LSB field order: pc[32], rs[5], rt[5], rs_value[32], rt_value[32], rd[5], alu_src1_is_pc, alu_src2_is_4, alu_src2_is_imm, alu_op[2], imm[32], br_beq, br_blt, br_bltu, br_jal, mem_to_reg, reg_w_en, dm_w_en, dm_r_en.
- fwd_a_sel  in  2  operand A source: 00 rs_value, 01 mem_fwd_data, 10 wb_fwd_data, 11 reserved (treated as 00).
- fwd_b_sel  in  2  operand B source; same encoding as fwd_a_sel.
- mem_fwd_data  in  32  ALU result currently in the MEM stage.
- wb_fwd_data  in  32  write-back data currently in the WB stage.
- exe_to_mem_bus  out  105  MSB→LSB field order: pc[32], alu_result[32], store_data[32], rd[5], mem_to_reg, reg_w_en, dm_w_en, dm_r_en.
- redirect_valid  out  1  branch taken or JAL in EXE.
- redirect_pc  out  32  target address = pc + imm.
- rs_exe, rt_exe, rd_exe  out  5 each  register indices held in the EXE stage, for the hazard unit.
- reg_w_en_exe, dm_r_en_exe  out  1 each  EXE-stage control bits, for load-use detection.

Behaviour:
- ID/EX register update, on posedge clk (priority top-down):
  - !rstn: clear to all zeros (asynchronous).
  - flushE: clear to all zeros.
  - bubbleE: hold current value.
  - otherwise: load id_to_exe_bus.
- flushE wins when flushE and bubbleE are asserted together.
- An all-zero register is a NOP: no write enables, no redirect.
- All other logic is combinational from the register and the forwarding inputs. EXE latency is 1 cycle from the ID/EX edge to a valid exe_to_mem_bus and redirect.
- Forwarded operands:
  - fa = rs_value mux per fwd_a_sel.
  - fb = rt_value mux per fwd_b_sel.
- ALU inputs:
  - src1 = alu_src1_is_pc ? pc : fa.
  - src2 = alu_src2_is_4 ? 32'd4 : alu_src2_is_imm ? imm : fb. alu_src2_is_4 has priority over alu_src2_is_imm.
- alu_op:
  - 00 ADD
  - 01 SUB
  - 10 AND
  - 11 OR
  - All arithmetic is modulo 2^32; no overflow flag.
- store_data = fb, i.e. the forwarded rt value, not the raw rt_value.
- Branch resolution on fa vs fb:
  - taken = br_jal | (br_beq & fa==fb) | (br_blt & $signed(fa)<$signed(fb)) | (br_bltu & fa<fb).
  - redirect_valid = taken.
  - redirect_pc = pc + imm, modulo 2^32; wraps with no fault.
- redirect_valid is combinational. The external hazard unit is responsible for flushing IF/ID and ID/EX on the following edge.
- Bubble: while bubbleE holds, the same instruction is presented every cycle and redirect_valid stays asserted if taken. Bubbled NOP insertion downstream is the MEM stage's job, not this block's.
- Reset values:
  - Register is zero, so redirect_valid=0, all write/read enables 0, rd_exe=rs_exe=rt_exe=0.
  - redirect_pc=0.
  - alu_result = fa+fb; this is 0 when fwd selects are 00.
- Reset asserted mid-operation clears the register immediately, without waiting for a clock edge.
- rd=0 is passed through unchanged; x0 suppression is handled in the register file.

Test Plan:
1. Load id bundle ADD: rs_value=5, rt_value=7, alu_op=00, reg_w_en=1, fwd=00/00 → next cycle alu_result=12, reg_w_en=1, redirect_valid=0.
2. Same bundle with fwd_a_sel=01, mem_fwd_data=100 → alu_result=107. Then fwd_b_sel=10, wb_fwd_data=3 → alu_result=103, store_data=3.
3. BLT: fa=0xFFFFFFFF, fb=1, br_blt=1, pc=0x100, imm=0xFFFFFFF0 → redirect_valid=1, redirect_pc=0xF0. Same operands with br_bltu=1 instead → redirect_valid=0.
4. JAL: pc=0x200, imm=0x40, alu_src1_is_pc=1, alu_src2_is_4=1 → alu_result=0x204, redirect_valid=1, redirect_pc=0x240.
5. Load a bundle, then bubbleE=1 for 2 cycles while the input changes → outputs unchanged for both cycles. Then assert flushE and bubbleE together → next cycle all enables 0, redirect_valid=0.
6. Drop rstn asynchronously between edges while reg_w_en=1 and a branch is taken → reg_w_en_exe and redirect_valid fall to 0 before the next posedge.
